regfile_write_arbiter: RTL

Shares the NBBPU register file's single write port between two writeback requesters: requester 0 is the execute/ALU result and requester 1 is the memory load result. Each requester has a valid/ready handshake into its own small FIFO. A round-robin arbiter pops at most one entry per cycle into a registered output stage, which drives the regfile write_lower_enable, write_upper_enable, address_write and write_data pins directly. A pending-register mask is exported so the issue logic can detect write-after-write hazards.

---
 rtl/regfile_write_arbiter_pkg.sv | 13 +
 rtl/regfile_write_arbiter_write_fifo.sv | 52 +++++
 rtl/regfile_write_arbiter.sv | 71 +++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: shared register-file widths, write entry layout and arbiter pointer type
package regfile_write_arbiter_pkg;
  localparam int REG_COUNT = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic lower;
    logic upper;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_e;
endpackage

// File: rtl/regfile_write_arbiter_write_fifo.sv
// write_fifo: per-requester write queue exposing its head and the addresses of occupied slots
module write_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                push,
  input  entry_t                              push_entry,
  input  logic                                pop,
  output logic                                ready,
  output logic                                empty,
  output entry_t                              head,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0]    addrs,
  output logic [DEPTH-1:0]                    valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) mem_q <= mem_d;
  assign ready = count_q < CW'(DEPTH);
  assign empty = count_q == '0;
  assign head = mem_q[rd_ptr_q];
  // A slot is live when its distance from the read pointer is below the count
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] off;
    assign off = PW'(i) - rd_ptr_q;
    assign valid[i] = CW'(off) < count_q;
    assign addrs[i] = mem_q[i].address;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the regfile write port between ALU and load writeback
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_lower,
  input  logic                  req0_upper,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_lower,
  input  logic                  req1_upper,
  output logic                  write_lower_enable,
  output logic                  write_upper_enable,
  output logic [ADDR_WIDTH-1:0] address_write,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [REG_COUNT-1:0]  pending
);
  entry_t in0, in1, head0, head1, out_q, out_d;
  logic push0, push1, pop0, pop1, empty0, empty1;
  logic [DEPTH-1:0] valid0, valid1;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addrs0, addrs1;
  req_e rr_q, rr_d;
  assign in0 = {req0_lower, req0_upper, req0_address, req0_data};
  assign in1 = {req1_lower, req1_upper, req1_address, req1_data};
  write_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clock(clock), .reset(reset), .push(push0), .push_entry(in0), .pop(pop0),
    .ready(req0_ready), .empty(empty0), .head(head0), .addrs(addrs0), .valid(valid0)
  );
  write_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clock(clock), .reset(reset), .push(push1), .push_entry(in1), .pop(pop1),
    .ready(req1_ready), .empty(empty1), .head(head1), .addrs(addrs1), .valid(valid1)
  );
  always_comb begin
    // Writes to r0 or with no lanes complete the handshake but are never queued
    push0 = req0_valid & req0_ready & (req0_address != '0) & (req0_lower | req0_upper);
    push1 = req1_valid & req1_ready & (req1_address != '0) & (req1_lower | req1_upper);
    pop1 = ~empty1 & (empty0 | rr_q == REQ1);
    pop0 = ~empty0 & ~pop1;
    rr_d = (~empty0 & ~empty1) ? (pop0 ? REQ1 : REQ0) : rr_q;
    out_d = pop0 ? head0 : pop1 ? head1 : entry_t'({2'b00, out_q.address, out_q.data});
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid0[i]) pending[addrs0[i]] = 1'b1;
      if (valid1[i]) pending[addrs1[i]] = 1'b1;
    end
    if (out_q.lower | out_q.upper) pending[out_q.address] = 1'b1;
    pending[0] = 1'b0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
      rr_q <= REQ0;
    end else begin
      out_q <= out_d;
      rr_q <= rr_d;
    end
  end
  assign write_lower_enable = out_q.lower;
  assign write_upper_enable = out_q.upper;
  assign address_write = out_q.address;
  assign write_data = out_q.data;
endmodule
